// File: rtl/fmul_rr_arbiter.sv
// fmul_rr_arbiter: shares one combinational FP32 multiplier between NUM_REQ
// requesters using a round-robin grant and a registered one-entry response.
//
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   req_valid   - per-requester request valid
//   req_ready   - per-requester grant, one-hot or zero, combinational
//   req_a/req_b - packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid   - response valid, held until rsp_ready
//   rsp_ready   - response consumer ready
//   rsp_result  - product of the granted operands
//   rsp_id      - index of the requester that owns rsp_result
//   busy        - high whenever the arbiter is not idle
//
// multiply_32 is the shared truncating FP32 multiplier: sign xor, biased
// exponent sum, 24x24 mantissa product normalised by one bit, no rounding
// and no special cases other than a zero operand giving +0.

module multiply_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);

  logic [47:0] prod;
  logic [9:0]  expSum;
  logic        unusedBits;

  always_comb begin
    prod   = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
    // A product of two [1,2) mantissas lies in [1,4); bit 47 set means
    // the result needs one right shift and an exponent increment.
    expSum = 10'(a_i[30:23]) + 10'(b_i[30:23]) - 10'd127 + 10'(prod[47]);
    p_o    = {a_i[31] ^ b_i[31], expSum[7:0],
              prod[47] ? prod[46:24] : prod[45:23]};
    if ((a_i[30:0] == 31'd0) || (b_i[30:0] == 31'd0)) begin
      p_o = 32'd0;
    end
  end

  // Truncated product bits and exponent overflow bits are dropped on purpose.
  assign unusedBits = ^{prod[22:0], expSum[9:8]};

endmodule

module fmul_rr_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q;
  logic [ID_W-1:0] rrPtr_q, rrPtr_d;
  logic [ID_W-1:0] opId_q, rspId_q;
  logic [WIDTH-1:0] opA_q, opB_q, rspResult_q, mulResult;
  logic            rspValid_q;

  logic            anyValid, grant;
  logic [ID_W-1:0] winner, searchIdx;
  logic [ID_W:0]   searchSum;
  logic [WIDTH-1:0] winA, winB;

  multiply_32 uMul (
    .a_i (opA_q),
    .b_i (opB_q),
    .p_o (mulResult)
  );

  // Round-robin search: first valid requester at or above rrPtr_q, wrapping.
  always_comb begin
    anyValid  = 1'b0;
    winner    = '0;
    searchSum = '0;
    searchIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      searchSum = {1'b0, rrPtr_q} + (ID_W+1)'(k);
      if (searchSum >= (ID_W+1)'(NUM_REQ)) begin
        searchSum = searchSum - (ID_W+1)'(NUM_REQ);
      end
      searchIdx = searchSum[ID_W-1:0];
      if (!anyValid && req_valid[searchIdx]) begin
        anyValid = 1'b1;
        winner   = searchIdx;
      end
    end
  end

  always_comb begin
    winA = '0;
    winB = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == winner) begin
        winA = req_a[i*WIDTH +: WIDTH];
        winB = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // A grant is only possible when the response slot is empty or draining;
  // rst_n gating keeps req_ready low for the whole reset period.
  assign grant     = rst_n && anyValid &&
                     ((state_q == IDLE) || ((state_q == DONE) && rsp_ready));
  assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
  assign rrPtr_d   = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      opA_q       <= '0;
      opB_q       <= '0;
      opId_q      <= '0;
      rspValid_q  <= 1'b0;
      rspResult_q <= '0;
      rspId_q     <= '0;
    end else begin
      if (grant) begin
        opA_q   <= winA;
        opB_q   <= winB;
        opId_q  <= winner;
        rrPtr_q <= rrPtr_d;
      end
      case (state_q)
        IDLE: begin
          if (grant) state_q <= BUSY;
        end
        BUSY: begin
          rspResult_q <= mulResult;
          rspId_q     <= opId_q;
          rspValid_q  <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= grant ? BUSY : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rspValid_q;
  assign rsp_result = rspResult_q;
  assign rsp_id     = rspId_q;
  assign busy       = (state_q != IDLE);

endmodule
